// File: rtl/proc_pkg.sv
// Shared opcodes, step encodings and IR field positions for mem_processor.
// Shift opcodes count as ALU operations only when PROC_SHIFT_EN is defined.
package proc_pkg;

    localparam logic [3:0] OpMv   = 4'd0;
    localparam logic [3:0] OpMvi  = 4'd1;
    localparam logic [3:0] OpAdd  = 4'd2;
    localparam logic [3:0] OpSub  = 4'd3;
    localparam logic [3:0] OpOr   = 4'd4;
    localparam logic [3:0] OpSlt  = 4'd5;
    localparam logic [3:0] OpSll  = 4'd6;
    localparam logic [3:0] OpSrl  = 4'd7;
    localparam logic [3:0] OpLd   = 4'd8;
    localparam logic [3:0] OpSt   = 4'd9;
    localparam logic [3:0] OpMvnz = 4'd10;

    localparam int unsigned IrW     = 10;
    localparam int unsigned IrOpMsb = 9;
    localparam int unsigned IrOpLsb = 6;
    localparam int unsigned IrXMsb  = 5;
    localparam int unsigned IrXLsb  = 3;
    localparam int unsigned IrYMsb  = 2;
    localparam int unsigned IrYLsb  = 0;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } step_e;

    typedef enum logic [1:0] {
        SelNone = 2'd0,
        SelReg  = 2'd1,
        SelDin  = 2'd2,
        SelG    = 2'd3
    } bus_sel_e;

    function automatic logic [3:0] ir_op(input logic [IrW-1:0] ir);
        return ir[IrOpMsb:IrOpLsb];
    endfunction

    function automatic logic [2:0] ir_x(input logic [IrW-1:0] ir);
        return ir[IrXMsb:IrXLsb];
    endfunction

    function automatic logic [2:0] ir_y(input logic [IrW-1:0] ir);
        return ir[IrYMsb:IrYLsb];
    endfunction

    // Opcodes that take the three-step A/G datapath.
    function automatic logic is_alu_op(input logic [3:0] op);
        logic alu;
        alu = (op == OpAdd) || (op == OpSub) || (op == OpOr) || (op == OpSlt);
`ifdef PROC_SHIFT_EN
        alu = alu || (op == OpSll) || (op == OpSrl);
`endif
        return alu;
    endfunction

endpackage

// File: rtl/mem_processor_if.sv
// Synchronous memory port of mem_processor: address/write data/strobe out, read data in.
interface mem_processor_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
);
    logic [DATA_W-1:0] DIN;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] DOUT;
    logic              W;

    modport master (
        input  DIN,
        output ADDR,
        output DOUT,
        output W
    );

    modport slave (
        output DIN,
        input  ADDR,
        input  DOUT,
        input  W
    );
endinterface

// File: rtl/proc_alu.sv
// Combinational ALU for mem_processor: add/sub/or/slt, plus sll/srl when PROC_SHIFT_EN is defined.
module proc_alu
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [3:0]        i_op,
    output logic [DATA_W-1:0] o_result
);

`ifdef PROC_SHIFT_EN
    localparam int unsigned ShW = $clog2(DATA_W);
`endif

    always_comb begin
        o_result = '0;
        case (i_op)
            OpAdd:   o_result = i_a + i_b;
            OpSub:   o_result = i_a - i_b;
            OpOr:    o_result = i_a | i_b;
            OpSlt:   o_result = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
`ifdef PROC_SHIFT_EN
            OpSll:   o_result = i_a << i_b[ShW-1:0];
            OpSrl:   o_result = i_a >> i_b[ShW-1:0];
`endif
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/mem_processor.sv
// Multi-cycle bus-based processor with eight registers (R7 = PC) and a synchronous memory port.
// Shift instructions are built only when PROC_SHIFT_EN is defined; otherwise they act as nop.
module mem_processor
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    mem_processor_if.master   mem,
    output logic              Done,
    output logic [DATA_W-1:0] BusWires,
    output logic [2:0]        Step
);

    logic [DATA_W-1:0] r_regs [8];
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_g;
    logic [IrW-1:0]    r_ir;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dout;
    step_e             r_step;

    step_e             w_step_next;
    bus_sel_e          w_bus_sel;
    logic [2:0]        w_bus_reg;
    logic [3:0]        w_op;
    logic [2:0]        w_x;
    logic [2:0]        w_y;
    logic              w_is_alu;
    logic              w_rx_ld;
    logic              w_pc_inc;
    logic              w_addr_ld;
    logic              w_dout_ld;
    logic              w_ir_ld;
    logic              w_a_ld;
    logic              w_g_ld;
    logic              w_write;
    logic [DATA_W-1:0] w_alu_result;

    assign w_op     = ir_op(r_ir);
    assign w_x      = ir_x(r_ir);
    assign w_y      = ir_y(r_ir);
    assign w_is_alu = is_alu_op(w_op);

    proc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_a      (r_a),
        .i_b      (BusWires),
        .i_op     (w_op),
        .o_result (w_alu_result)
    );

    always_comb begin
        w_step_next = r_step;
        w_bus_sel   = SelNone;
        w_bus_reg   = 3'd0;
        w_rx_ld     = 1'b0;
        w_pc_inc    = 1'b0;
        w_addr_ld   = 1'b0;
        w_dout_ld   = 1'b0;
        w_ir_ld     = 1'b0;
        w_a_ld      = 1'b0;
        w_g_ld      = 1'b0;
        w_write     = 1'b0;
        Done        = 1'b0;
        unique case (r_step)
            T0: begin
                if (Run) begin
                    w_bus_sel   = SelReg;
                    w_bus_reg   = 3'd7;
                    w_addr_ld   = 1'b1;
                    w_pc_inc    = 1'b1;
                    w_step_next = T1;
                end
            end
            T1: w_step_next = T2;
            T2: begin
                w_bus_sel   = SelDin;
                w_ir_ld     = 1'b1;
                w_step_next = T3;
            end
            T3: begin
                w_step_next = T4;
                if (w_op == OpMv) begin
                    w_bus_sel   = SelReg;
                    w_bus_reg   = w_y;
                    w_rx_ld     = 1'b1;
                    Done        = 1'b1;
                    w_step_next = T0;
                end else if (w_op == OpMvi) begin
                    w_bus_sel = SelReg;
                    w_bus_reg = 3'd7;
                    w_addr_ld = 1'b1;
                    w_pc_inc  = 1'b1;
                end else if (w_is_alu) begin
                    w_bus_sel = SelReg;
                    w_bus_reg = w_x;
                    w_a_ld    = 1'b1;
                end else if (w_op == OpLd) begin
                    w_bus_sel = SelReg;
                    w_bus_reg = w_y;
                    w_addr_ld = 1'b1;
                end else if (w_op == OpSt) begin
                    w_bus_sel = SelReg;
                    w_bus_reg = w_y;
                    w_addr_ld = 1'b1;
                    w_dout_ld = 1'b1;
                end else if (w_op == OpMvnz) begin
                    w_bus_sel   = SelReg;
                    w_bus_reg   = w_y;
                    w_rx_ld     = (r_g != '0);
                    Done        = 1'b1;
                    w_step_next = T0;
                end else begin
                    Done        = 1'b1;
                    w_step_next = T0;
                end
            end
            T4: begin
                w_step_next = T5;
                if (w_is_alu) begin
                    w_bus_sel = SelReg;
                    w_bus_reg = w_y;
                    w_g_ld    = 1'b1;
                end else if (w_op == OpSt) begin
                    w_write     = 1'b1;
                    Done        = 1'b1;
                    w_step_next = T0;
                end else if ((w_op != OpMvi) && (w_op != OpLd)) begin
                    w_step_next = T0;
                end
            end
            T5: begin
                w_step_next = T0;
                if (w_is_alu) begin
                    w_bus_sel = SelG;
                    w_rx_ld   = 1'b1;
                    Done      = 1'b1;
                end else if ((w_op == OpMvi) || (w_op == OpLd)) begin
                    w_bus_sel = SelDin;
                    w_rx_ld   = 1'b1;
                    Done      = 1'b1;
                end
            end
            default: w_step_next = T0;
        endcase
    end

    // Single-source bus; idle steps read as zero.
    always_comb begin
        BusWires = '0;
        unique case (w_bus_sel)
            SelReg:  BusWires = r_regs[w_bus_reg];
            SelDin:  BusWires = mem.DIN;
            SelG:    BusWires = r_g;
            default: BusWires = '0;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
            r_a    <= '0;
            r_g    <= '0;
            r_ir   <= '0;
            r_addr <= '0;
            r_dout <= '0;
            r_step <= T0;
        end else begin
            r_step <= w_step_next;
            if (w_ir_ld) begin
                r_ir <= mem.DIN[IrW-1:0];
            end
            if (w_a_ld) begin
                r_a <= BusWires;
            end
            if (w_g_ld) begin
                r_g <= w_alu_result;
            end
            if (w_addr_ld) begin
                r_addr <= BusWires[ADDR_W-1:0];
            end
            if (w_dout_ld) begin
                r_dout <= r_regs[w_x];
            end
            // A bus write to R7 and a PC increment never share a step.
            for (int i = 0; i < 8; i++) begin
                if (w_rx_ld && (w_x == 3'(i))) begin
                    r_regs[i] <= BusWires;
                end else if ((i == 7) && w_pc_inc) begin
                    r_regs[i] <= r_regs[i] + 1'b1;
                end
            end
        end
    end

    assign mem.ADDR = r_addr;
    assign mem.DOUT = r_dout;
    assign mem.W    = w_write;
    assign Step     = r_step;

endmodule

// File: tb/tb_mem_processor.sv
// Directed bench for mem_processor: runs small programs from a modelled synchronous memory.
module tb_mem_processor;
    import proc_pkg::*;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 8;

    logic              Clock = 1'b0;
    logic              Resetn = 1'b1;
    logic              Run = 1'b0;
    logic              Done;
    logic [DATA_W-1:0] BusWires;
    logic [2:0]        Step;

    int checks = 0;
    int failures = 0;

    logic              clr = 1'b0;
    logic              ld_en = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;
    logic [DATA_W-1:0] mem_arr [256];

    mem_processor_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

    mem_processor #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Run      (Run),
        .mem      (bus_if),
        .Done     (Done),
        .BusWires (BusWires),
        .Step     (Step)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= '0;
        end else if (ld_en) begin
            mem_arr[ld_addr] <= ld_data;
        end else if (bus_if.W) begin
            mem_arr[bus_if.ADDR] <= bus_if.DOUT;
        end
        bus_if.DIN <= mem_arr[bus_if.ADDR];
    end

`ifdef PROC_SHIFT_EN
    localparam logic [2:0]        ShStep = 3'd5;
    localparam logic [DATA_W-1:0] SllRes = 16'h0006;
`else
    localparam logic [2:0]        ShStep = 3'd3;
    localparam logic [DATA_W-1:0] SllRes = 16'h0003;
`endif

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [2:0] x,
                                        input logic [2:0] y);
        return {6'd0, op, x, y};
    endfunction

    task automatic reset_dut();
        @(negedge Clock);
        Resetn = 1'b0;
        Run    = 1'b0;
        clr    = 1'b1;
        @(negedge Clock);
        clr    = 1'b0;
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        @(negedge Clock);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge Clock);
        ld_en   = 1'b0;
    endtask

    task automatic go();
        @(negedge Clock);
        Resetn = 1'b1;
        Run    = 1'b1;
    endtask

    // Returns the Step at which Done was seen, or 7 if it never came.
    task automatic wait_done(output logic [2:0] st);
        logic seen;
        seen = 1'b0;
        st   = 3'd7;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge Clock);
            if (Done) begin
                st   = Step;
                seen = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge Clock);
        Resetn = 1'b0;
        #1;
        checks++; if (Step !== 3'd0) begin failures++; $display("FAIL reset_step got %0d want 0", Step); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", Done); end
        checks++; if (bus_if.W !== 1'b0) begin failures++; $display("FAIL reset_w got %b want 0", bus_if.W); end
        checks++; if (bus_if.ADDR !== 8'h00) begin failures++; $display("FAIL reset_addr got %h want 00", bus_if.ADDR); end
        checks++; if (dut.r_regs[7] !== 16'h0) begin failures++; $display("FAIL reset_pc got %h want 0000", dut.r_regs[7]); end
    endtask

    task automatic test_mvi();
        logic [2:0] st;
        reset_dut();
        poke(8'd0, ins(OpMvi, 3'd0, 3'd0));
        poke(8'd1, 16'h0005);
        go();
        wait_done(st);
        checks++; if (st !== 3'd5) begin failures++; $display("FAIL mvi_done_step got %0d want 5", st); end
        @(negedge Clock);
        checks++; if (dut.r_regs[0] !== 16'h0005) begin failures++; $display("FAIL mvi_r0 got %h want 0005", dut.r_regs[0]); end
        checks++; if (dut.r_regs[7] !== 16'h0002) begin failures++; $display("FAIL mvi_pc got %h want 0002", dut.r_regs[7]); end
        checks++; if (Step !== 3'd0) begin failures++; $display("FAIL mvi_back_t0 got %0d want 0", Step); end
    endtask

    task automatic test_alu();
        logic [2:0] st;
        reset_dut();
        poke(8'd0, ins(OpMvi, 3'd0, 3'd0)); poke(8'd1, 16'h0005);
        poke(8'd2, ins(OpMvi, 3'd1, 3'd0)); poke(8'd3, 16'h0007);
        poke(8'd4, ins(OpAdd, 3'd0, 3'd1));
        poke(8'd5, ins(OpSub, 3'd0, 3'd1));
        poke(8'd6, ins(OpMvi, 3'd0, 3'd0)); poke(8'd7, 16'hFFFF);
        poke(8'd8, ins(OpMvi, 3'd1, 3'd0)); poke(8'd9, 16'h0001);
        poke(8'd10, ins(OpAdd, 3'd0, 3'd1));
        go();
        wait_done(st); wait_done(st);
        wait_done(st);
        checks++; if (st !== 3'd5) begin failures++; $display("FAIL add_done_step got %0d want 5", st); end
        @(negedge Clock);
        checks++; if (dut.r_regs[0] !== 16'h000C) begin failures++; $display("FAIL add_r0 got %h want 000c", dut.r_regs[0]); end
        checks++; if (dut.r_g !== 16'h000C) begin failures++; $display("FAIL add_g got %h want 000c", dut.r_g); end
        wait_done(st);
        @(negedge Clock);
        checks++; if (dut.r_regs[0] !== 16'h0005) begin failures++; $display("FAIL sub_r0 got %h want 0005", dut.r_regs[0]); end
        wait_done(st); wait_done(st); wait_done(st);
        @(negedge Clock);
        checks++; if (dut.r_regs[0] !== 16'h0000) begin failures++; $display("FAIL add_wrap_r0 got %h want 0000", dut.r_regs[0]); end
        checks++; if (dut.r_g !== 16'h0000) begin failures++; $display("FAIL add_wrap_g got %h want 0000", dut.r_g); end
    endtask

    task automatic test_logic();
        logic [2:0] st;
        reset_dut();
        poke(8'd0, ins(OpMvi, 3'd0, 3'd0)); poke(8'd1, 16'h0003);
        poke(8'd2, ins(OpMvi, 3'd2, 3'd0)); poke(8'd3, 16'h8000);
        poke(8'd4, ins(OpOr, 3'd2, 3'd0));
        poke(8'd5, ins(OpSlt, 3'd2, 3'd0));
        poke(8'd6, ins(OpSlt, 3'd0, 3'd2));
        poke(8'd7, ins(OpMv, 3'd3, 3'd2));
        poke(8'd8, ins(4'd11, 3'd1, 3'd2));
        go();
        wait_done(st); wait_done(st);
        wait_done(st);
        @(negedge Clock);
        checks++; if (dut.r_regs[2] !== 16'h8003) begin failures++; $display("FAIL or_r2 got %h want 8003", dut.r_regs[2]); end
        wait_done(st);
        @(negedge Clock);
        checks++; if (dut.r_regs[2] !== 16'h0001) begin failures++; $display("FAIL slt_neg_r2 got %h want 0001", dut.r_regs[2]); end
        wait_done(st);
        @(negedge Clock);
        checks++; if (dut.r_regs[0] !== 16'h0000) begin failures++; $display("FAIL slt_false_r0 got %h want 0000", dut.r_regs[0]); end
        wait_done(st);
        checks++; if (st !== 3'd3) begin failures++; $display("FAIL mv_done_step got %0d want 3", st); end
        @(negedge Clock);
        checks++; if (dut.r_regs[3] !== 16'h0001) begin failures++; $display("FAIL mv_r3 got %h want 0001", dut.r_regs[3]); end
        wait_done(st);
        checks++; if (st !== 3'd3) begin failures++; $display("FAIL nop_done_step got %0d want 3", st); end
        @(negedge Clock);
        checks++; if (dut.r_regs[1] !== 16'h0000) begin failures++; $display("FAIL nop_r1 got %h want 0000", dut.r_regs[1]); end
        checks++; if (dut.r_regs[7] !== 16'h0009) begin failures++; $display("FAIL nop_pc got %h want 0009", dut.r_regs[7]); end
    endtask

    task automatic test_mem();
        logic [2:0]  st;
        logic [7:0]  waddr;
        logic [15:0] wdout;
        logic        seen;
        int          wcnt;
        reset_dut();
        poke(8'd0, ins(OpMvi, 3'd2, 3'd0)); poke(8'd1, 16'h0010);
        poke(8'd2, ins(OpMvi, 3'd3, 3'd0)); poke(8'd3, 16'hBEEF);
        poke(8'd4, ins(OpSt, 3'd3, 3'd2));
        poke(8'd5, ins(OpLd, 3'd4, 3'd2));
        go();
        wait_done(st); wait_done(st);
        wcnt = 0; seen = 1'b0; st = 3'd7; waddr = '0; wdout = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge Clock);
            if (bus_if.W) begin
                wcnt++;
                waddr = bus_if.ADDR;
                wdout = bus_if.DOUT;
            end
            if (Done) begin
                st   = Step;
                seen = 1'b1;
            end
        end
        checks++; if (st !== 3'd4) begin failures++; $display("FAIL st_done_step got %0d want 4", st); end
        checks++; if (wcnt != 1) begin failures++; $display("FAIL st_w_cycles got %0d want 1", wcnt); end
        checks++; if (waddr !== 8'h10) begin failures++; $display("FAIL st_addr got %h want 10", waddr); end
        checks++; if (wdout !== 16'hBEEF) begin failures++; $display("FAIL st_dout got %h want beef", wdout); end
        wait_done(st);
        checks++; if (st !== 3'd5) begin failures++; $display("FAIL ld_done_step got %0d want 5", st); end
        @(negedge Clock);
        checks++; if (dut.r_regs[4] !== 16'hBEEF) begin failures++; $display("FAIL ld_r4 got %h want beef", dut.r_regs[4]); end
        checks++; if (mem_arr[16] !== 16'hBEEF) begin failures++; $display("FAIL st_mem got %h want beef", mem_arr[16]); end
    endtask

    task automatic test_mvnz();
        logic [2:0] st;
        reset_dut();
        poke(8'd0, ins(OpMvi, 3'd5, 3'd0)); poke(8'd1, 16'h0020);
        poke(8'd2, ins(OpMvnz, 3'd7, 3'd5));
        poke(8'd3, ins(OpMvi, 3'd0, 3'd0)); poke(8'd4, 16'h0001);
        poke(8'd5, ins(OpMvi, 3'd1, 3'd0)); poke(8'd6, 16'h0000);
        poke(8'd7, ins(OpAdd, 3'd0, 3'd1));
        poke(8'd8, ins(OpMvnz, 3'd7, 3'd5));
        poke(8'h20, ins(OpMvi, 3'd6, 3'd0)); poke(8'h21, 16'h1234);
        go();
        wait_done(st);
        wait_done(st);
        checks++; if (st !== 3'd3) begin failures++; $display("FAIL mvnz0_done_step got %0d want 3", st); end
        @(negedge Clock);
        checks++; if (dut.r_regs[7] !== 16'h0003) begin failures++; $display("FAIL mvnz0_pc got %h want 0003", dut.r_regs[7]); end
        wait_done(st); wait_done(st); wait_done(st);
        wait_done(st);
        @(negedge Clock);
        checks++; if (dut.r_g !== 16'h0001) begin failures++; $display("FAIL mvnz1_g got %h want 0001", dut.r_g); end
        checks++; if (dut.r_regs[7] !== 16'h0020) begin failures++; $display("FAIL mvnz1_pc got %h want 0020", dut.r_regs[7]); end
        @(negedge Clock);
        checks++; if (bus_if.ADDR !== 8'h20) begin failures++; $display("FAIL jump_fetch_addr got %h want 20", bus_if.ADDR); end
        wait_done(st);
        @(negedge Clock);
        checks++; if (dut.r_regs[6] !== 16'h1234) begin failures++; $display("FAIL jump_r6 got %h want 1234", dut.r_regs[6]); end
        checks++; if (dut.r_regs[7] !== 16'h0022) begin failures++; $display("FAIL jump_pc got %h want 0022", dut.r_regs[7]); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] st;
        logic       at_t4;
        reset_dut();
        poke(8'd0, ins(OpMvi, 3'd0, 3'd0)); poke(8'd1, 16'h0005);
        poke(8'd2, ins(OpMvi, 3'd1, 3'd0)); poke(8'd3, 16'h0007);
        poke(8'd4, ins(OpAdd, 3'd0, 3'd1));
        go();
        wait_done(st); wait_done(st);
        at_t4 = 1'b0;
        for (int i = 0; i < 20 && !at_t4; i++) begin
            @(negedge Clock);
            at_t4 = (Step == 3'd4);
        end
        checks++; if (dut.r_a !== 16'h0005) begin failures++; $display("FAIL mid_pre_a got %h want 0005", dut.r_a); end
        Resetn = 1'b0;
        #1;
        checks++; if (Step !== 3'd0) begin failures++; $display("FAIL mid_step got %0d want 0", Step); end
        checks++; if (dut.r_regs[0] !== 16'h0) begin failures++; $display("FAIL mid_r0 got %h want 0000", dut.r_regs[0]); end
        checks++; if (dut.r_regs[1] !== 16'h0) begin failures++; $display("FAIL mid_r1 got %h want 0000", dut.r_regs[1]); end
        checks++; if (dut.r_regs[7] !== 16'h0) begin failures++; $display("FAIL mid_pc got %h want 0000", dut.r_regs[7]); end
        checks++; if (dut.r_a !== 16'h0) begin failures++; $display("FAIL mid_a got %h want 0000", dut.r_a); end
        checks++; if (dut.r_ir !== 10'h0) begin failures++; $display("FAIL mid_ir got %h want 000", dut.r_ir); end
        checks++; if (bus_if.ADDR !== 8'h00) begin failures++; $display("FAIL mid_addr got %h want 00", bus_if.ADDR); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL mid_done got %b want 0", Done); end
    endtask

    task automatic test_shift();
        logic [2:0] st;
        reset_dut();
        poke(8'd0, ins(OpMvi, 3'd0, 3'd0)); poke(8'd1, 16'h0003);
        poke(8'd2, ins(OpMvi, 3'd1, 3'd0)); poke(8'd3, 16'h0001);
        poke(8'd4, ins(OpSll, 3'd0, 3'd1));
        poke(8'd5, ins(OpSrl, 3'd0, 3'd1));
        go();
        wait_done(st); wait_done(st);
        wait_done(st);
        checks++; if (st !== ShStep) begin failures++; $display("FAIL sll_done_step got %0d want %0d", st, ShStep); end
        @(negedge Clock);
        checks++; if (dut.r_regs[0] !== SllRes) begin failures++; $display("FAIL sll_r0 got %h want %h", dut.r_regs[0], SllRes); end
        wait_done(st);
        @(negedge Clock);
        checks++; if (dut.r_regs[0] !== 16'h0003) begin failures++; $display("FAIL srl_r0 got %h want 0003", dut.r_regs[0]); end
    endtask

    task automatic test_run_hold();
        reset_dut();
        poke(8'd0, ins(OpMvi, 3'd0, 3'd0)); poke(8'd1, 16'h0005);
        @(negedge Clock);
        Resetn = 1'b1;
        Run    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            checks++; if (Step !== 3'd0) begin failures++; $display("FAIL hold_step[%0d] got %0d want 0", i, Step); end
            checks++; if (Done !== 1'b0) begin failures++; $display("FAIL hold_done[%0d] got %b want 0", i, Done); end
        end
        checks++; if (dut.r_regs[7] !== 16'h0) begin failures++; $display("FAIL hold_pc got %h want 0000", dut.r_regs[7]); end
        checks++; if (BusWires !== 16'h0) begin failures++; $display("FAIL hold_bus got %h want 0000", BusWires); end
        Run = 1'b1;
        @(posedge Clock);
        #1;
        checks++; if (Step !== 3'd1) begin failures++; $display("FAIL start_step got %0d want 1", Step); end
        checks++; if (bus_if.ADDR !== 8'h00) begin failures++; $display("FAIL start_addr got %h want 00", bus_if.ADDR); end
        checks++; if (dut.r_regs[7] !== 16'h0001) begin failures++; $display("FAIL start_pc got %h want 0001", dut.r_regs[7]); end
    endtask

    initial begin
        test_reset();
        test_mvi();
        test_alu();
        test_logic();
        test_mem();
        test_mvnz();
        test_reset_mid();
        test_shift();
        test_run_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
